// File: rtl/speckle_scan_pkg.sv
// speckle_scan_pkg: state encoding, shift-register control bundle and width helpers
// shared by the speckle pixel-scan engine.
package speckle_scan_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SR_RST,
        S_ROW_SHIFT,
        S_COL_SHIFT,
        S_SETTLE,
        S_CONV,
        S_WAIT,
        S_WRITE,
        S_DONE
    } scan_state_e;

    typedef struct packed {
        logic row_clk;
        logic row_rst;
        logic row_data;
        logic row_ena;
        logic col_clk;
        logic col_rst;
        logic col_data;
    } sr_ctrl_t;

    localparam int unsigned SR_RST_TICKS = 2;

    function automatic int unsigned calc_nb_addr(input int unsigned cols, input int unsigned rows);
        return (cols * rows > 1) ? $clog2(cols * rows) : 1;
    endfunction

    function automatic int unsigned calc_nb_acc(input int unsigned nb_data, input int unsigned avg_log2_max);
        return nb_data + avg_log2_max;
    endfunction

    localparam int unsigned NB_ADDR = calc_nb_addr(24, 24);
    localparam int unsigned NB_ACC  = calc_nb_acc(12, 4);

endpackage

// File: rtl/speckle_scan_engine_if.sv
// speckle_scan_engine_if: XADC conversion handshake and frame-RAM write port of the scan engine.
interface speckle_scan_engine_if #(
    parameter int unsigned NB_DATA = 12,
    parameter int unsigned NB_ADDR = 10
);
    logic               adc_trigger;
    logic [NB_DATA-1:0] adc_val;
    logic               adc_done;
    logic               ram_we;
    logic [NB_ADDR-1:0] ram_addr;
    logic [NB_DATA:0]   ram_data;

    modport master (
        output adc_trigger, ram_we, ram_addr, ram_data,
        input  adc_val, adc_done
    );

    modport slave (
        input  adc_trigger, ram_we, ram_addr, ram_data,
        output adc_val, adc_done
    );
endinterface

// File: rtl/scan_tick_div.sv
// scan_tick_div: free-running 0..div counter producing a one-cycle tick when it reaches div;
// restart_i forces the count back to 0 on the next cycle.
module scan_tick_div #(
    parameter int unsigned NB_DIV = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart_i,
    input  logic [NB_DIV-1:0] div_i,
    output logic              tick_o
);
    logic [NB_DIV-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == div_i);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || tick_o) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/speckle_scan_engine.sv
// speckle_scan_engine: one-hot row/column scan, per-pixel 2^k ADC averaging and threshold flag.
// Optional ADC done timeout in WAIT is enabled by defining SSC_SCAN_TIMEOUT_EN.
module speckle_scan_engine
    import speckle_scan_pkg::*;
#(
    parameter int unsigned COLS           = 24,
    parameter int unsigned ROWS           = 24,
    parameter int unsigned NB_DATA        = 12,
    parameter int unsigned NB_DIV         = 24,
    parameter int unsigned AVG_LOG2_MAX   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [NB_DIV-1:0]    i_clk_div,
    input  logic [2:0]           i_avg_log2,
    input  logic [NB_DATA-1:0]   i_umbral,
    speckle_scan_engine_if.master bus,
    output logic                 o_chip_row_clk,
    output logic                 o_chip_row_rst,
    output logic                 o_chip_row_data,
    output logic                 o_chip_row_ena,
    output logic                 o_chip_col_clk,
    output logic                 o_chip_col_rst,
    output logic                 o_chip_col_data,
    output logic                 o_busy,
    output logic                 o_frame_done,
    output logic                 o_adc_timeout
);
    localparam int unsigned ADDR_W = calc_nb_addr(COLS, ROWS);
    localparam int unsigned ACC_W  = calc_nb_acc(NB_DATA, AVG_LOG2_MAX);
    localparam int unsigned COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned SAMP_W = AVG_LOG2_MAX + 1;

    if (COLS < 1 || ROWS < 1 || AVG_LOG2_MAX > 7 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("speckle_scan_engine: unsupported parameter set");
    end

    scan_state_e        state_q, state_d;
    logic [1:0]         ph_q, ph_d;
    logic [NB_DIV-1:0]  div_q, div_d;
    logic [2:0]         k_q, k_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [ADDR_W-1:0]  addr_q, addr_d, ram_addr_q, ram_addr_d;
    logic [ACC_W-1:0]   acc_q, acc_d, acc_sum;
    logic [SAMP_W-1:0]  samp_q, samp_d, samp_inc;
    logic [NB_DATA-1:0] avg;
    logic [NB_DATA:0]   ram_data_q, ram_data_d;
    sr_ctrl_t           ctrl_q, ctrl_d;
    logic               trig_q, we_q, busy_q, done_q, timeout_q, timeout_d;
    logic               tick, restart, tmo_hit;

    assign restart = (state_d != state_q);

    scan_tick_div #(.NB_DIV(NB_DIV)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart_i(restart),
        .div_i    (div_q),
        .tick_o   (tick)
    );

`ifdef SSC_SCAN_TIMEOUT_EN
    localparam int unsigned WCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [WCNT_W-1:0] wcnt_q;

    assign tmo_hit = (state_q == S_WAIT) && !bus.adc_done && (wcnt_q == WCNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          wcnt_q <= '0;
        else if (state_q != S_WAIT || restart) wcnt_q <= '0;
        else                                 wcnt_q <= wcnt_q + 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign acc_sum  = acc_q + ACC_W'(bus.adc_val);
    assign avg      = NB_DATA'(acc_sum >> k_q);
    assign samp_inc = samp_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        div_d      = div_q;
        k_d        = k_q;
        col_d      = col_q;
        row_d      = row_q;
        addr_d     = addr_q;
        acc_d      = acc_q;
        samp_d     = samp_q;
        timeout_d  = timeout_q;
        ram_addr_d = '0;
        ram_data_d = '0;
        case (state_q)
            S_IDLE: if (i_start) begin
                state_d   = S_SR_RST;
                div_d     = i_clk_div;
                k_d       = (i_avg_log2 > 3'(AVG_LOG2_MAX)) ? 3'(AVG_LOG2_MAX) : i_avg_log2;
                acc_d     = '0;
                samp_d    = '0;
                col_d     = '0;
                row_d     = '0;
                addr_d    = '0;
                timeout_d = 1'b0;
            end
            S_SR_RST: if (tick) begin
                if (ph_q == 2'(SR_RST_TICKS - 1)) state_d = S_ROW_SHIFT;
                else                              ph_d    = ph_q + 1'b1;
            end
            // Both shift states: phase 0 = clock high tick, phase 1 = clock low tick.
            S_ROW_SHIFT, S_COL_SHIFT: if (tick) begin
                if (ph_q != '0) state_d = (state_q == S_ROW_SHIFT) ? S_COL_SHIFT : S_SETTLE;
                else            ph_d    = 2'd1;
            end
            S_SETTLE: if (tick) state_d = S_CONV;
            S_CONV:   state_d = S_WAIT;
            S_WAIT: begin
                if (bus.adc_done) begin
                    acc_d  = acc_sum;
                    samp_d = samp_inc;
                    if (samp_inc < (SAMP_W'(1) << k_q)) begin
                        state_d = S_CONV;
                    end else begin
                        state_d    = S_WRITE;
                        ram_addr_d = addr_q;
                        ram_data_d = {avg >= i_umbral, avg};
                    end
                end else if (tmo_hit) begin
                    timeout_d  = 1'b1;
                    state_d    = S_WRITE;
                    ram_addr_d = addr_q;
                end
            end
            S_WRITE: begin
                acc_d  = '0;
                samp_d = '0;
                addr_d = addr_q + 1'b1;
                if (col_q == COL_W'(COLS - 1)) begin
                    col_d = '0;
                    if (row_q == ROW_W'(ROWS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        row_d   = row_q + 1'b1;
                        state_d = S_ROW_SHIFT;
                    end
                end else begin
                    col_d   = col_q + 1'b1;
                    state_d = S_COL_SHIFT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (i_abort) begin
            state_d    = S_IDLE;
            timeout_d  = 1'b0;
            ram_addr_d = '0;
            ram_data_d = '0;
        end
        if (restart) ph_d = '0;

        // Outputs are decoded from the next state so the registered copies line up with state_q.
        ctrl_d = '0;
        case (state_d)
            S_SR_RST: begin
                ctrl_d.row_rst = 1'b1;
                ctrl_d.col_rst = 1'b1;
            end
            S_ROW_SHIFT: begin
                ctrl_d.row_data = (row_d == '0);
                ctrl_d.row_clk  = (ph_d == '0);
                ctrl_d.col_rst  = (ph_d == '0);
            end
            S_COL_SHIFT: begin
                ctrl_d.col_data = (col_d == '0);
                ctrl_d.col_clk  = (ph_d == '0);
            end
            S_SETTLE, S_CONV, S_WAIT, S_WRITE: ctrl_d.row_ena = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ph_q       <= '0;
            div_q      <= '0;
            k_q        <= '0;
            col_q      <= '0;
            row_q      <= '0;
            addr_q     <= '0;
            acc_q      <= '0;
            samp_q     <= '0;
            timeout_q  <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            ctrl_q     <= '0;
            trig_q     <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            div_q      <= div_d;
            k_q        <= k_d;
            col_q      <= col_d;
            row_q      <= row_d;
            addr_q     <= addr_d;
            acc_q      <= acc_d;
            samp_q     <= samp_d;
            timeout_q  <= timeout_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            ctrl_q     <= ctrl_d;
            trig_q     <= (state_d == S_CONV);
            we_q       <= (state_d == S_WRITE);
            busy_q     <= (state_d != S_IDLE) && (state_d != S_DONE);
            done_q     <= (state_d == S_DONE);
        end
    end

    assign bus.adc_trigger = trig_q;
    assign bus.ram_we      = we_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_data    = ram_data_q;
    assign o_chip_row_clk  = ctrl_q.row_clk;
    assign o_chip_row_rst  = ctrl_q.row_rst;
    assign o_chip_row_data = ctrl_q.row_data;
    assign o_chip_row_ena  = ctrl_q.row_ena;
    assign o_chip_col_clk  = ctrl_q.col_clk;
    assign o_chip_col_rst  = ctrl_q.col_rst;
    assign o_chip_col_data = ctrl_q.col_data;
    assign o_busy          = busy_q;
    assign o_frame_done    = done_q;
    assign o_adc_timeout   = timeout_q;
endmodule

// File: doc/speckle_scan_engine.md
# speckle_scan_engine

Parametrised pixel-scan engine that replaces the fixed-size scan logic inside the speckle sensor controller. It walks a one-hot token through the chip row and column shift registers, pulses the XADC `convst` for every pixel, and averages 2^k conversions per pixel. It compares the average against a threshold and writes `{flag, average}` into the frame BRAM. It sits between the XADC wrapper, which provides `i_adc_val` and `i_adc_done`, and the frame RAM. Dividers, threshold and averaging depth come from the VIO at run time.

## Interface
- `COLS`, 24, pixel columns (≥1)
- `ROWS`, 24, pixel rows (≥1)
- `NB_DATA`, 12, ADC sample width
- `NB_DIV`, 24, shift-clock divider width
- `AVG_LOG2_MAX`, 4, maximum log2 of averaging depth
- `TIMEOUT_CYCLES`, 4096, ADC done timeout; used only with `SSC_SCAN_TIMEOUT_EN`
- `clk`, in, 1, system clock (125 MHz)
- `rst_n`, in, 1, asynchronous active-low reset
- `i_start`, in, 1, one-cycle frame start; ignored while busy
- `i_abort`, in, 1, abort the scan and return to IDLE
- `i_clk_div`, in, NB_DIV, tick period minus 1; sampled at start
- `i_avg_log2`, in, 3, averaging exponent k; sampled at start and clamped to AVG_LOG2_MAX
- `i_umbral`, in, NB_DATA, threshold
- `i_adc_val`, in, NB_DATA, conversion result
- `i_adc_done`, in, 1, end-of-conversion pulse
- `o_adc_trigger`, out, 1, one-cycle convst pulse
- `o_chip_row_clk`, `o_chip_row_rst`, `o_chip_row_data`, `o_chip_row_ena`, out, 1 each, row shift-register controls
- `o_chip_col_clk`, `o_chip_col_rst`, `o_chip_col_data`, out, 1 each, column shift-register controls
- `o_ram_we`, out, 1, write strobe
- `o_ram_addr`, out, clog2(COLS*ROWS), pixel address, `row*COLS+col`
- `o_ram_data`, out, NB_DATA+1, `{avg>=i_umbral, avg}`
- `o_busy`, out, 1, high from the cycle after `i_start` until IDLE
- `o_frame_done`, out, 1, one-cycle pulse at the end of a frame
- `o_adc_timeout`, out, 1, sticky timeout flag

## Operation
- States: IDLE, SR_RST, ROW_SHIFT, COL_SHIFT, SETTLE, CONV, WAIT, WRITE, DONE.
- Tick: the divider counts 0..div and asserts a tick on the cycle the count equals div. With div=0 a tick occurs every cycle. The divider restarts from 0 on every state entry.
- IDLE → SR_RST on `i_start`. Latches div and k, clears the accumulator, the counters and `o_adc_timeout`.
- SR_RST: `row_rst` and `col_rst` held high for 2 ticks, then → ROW_SHIFT.
- ROW_SHIFT:
  - `row_data` = (row==0); `row_clk` high for 1 tick, then low for 1 tick.
  - `col_rst` high for the first tick.
  - Then → COL_SHIFT.
- COL_SHIFT: `col_data` = (col==0); `col_clk` high for 1 tick, then low for 1 tick, then → SETTLE.
- SETTLE: `row_ena` high (it stays high through WRITE); wait 1 tick, then → CONV.
- CONV: `o_adc_trigger`=1 for exactly one cycle, then → WAIT.
- WAIT: on `i_adc_done`, add `i_adc_val` to the accumulator and increment the sample count.
  - If count < 2^k, → CONV.
  - Otherwise → WRITE.
- WRITE: avg = acc >> k. The accumulator is NB_DATA+AVG_LOG2_MAX bits wide and never overflows.
  - `o_ram_we`=1 for one cycle.
  - Clear the accumulator and the sample count.
  - Advance col. If col wraps from COLS-1, advance row and go → ROW_SHIFT; otherwise → COL_SHIFT.
  - After the last pixel, → DONE.
- DONE: `o_frame_done`=1 for one cycle, then → IDLE.
- `i_abort` in any state: next state is IDLE, all outputs return to their reset values, and no `o_frame_done` is issued. `i_abort` has priority over a simultaneous `i_start`.
- An `i_adc_done` that arrives outside WAIT is ignored.
- Threshold compare is unsigned; equality sets the flag.

## Timing
- Reset value of every output is 0. The FSM resets to IDLE; the counters and the accumulator reset to 0.
- All outputs are registered.
- `o_ram_addr` and `o_ram_data` are valid in the same cycle as `o_ram_we`.
- Latency from `i_done` (the last sample) to `o_ram_we` is 1 cycle.
- `o_adc_trigger` follows entry to CONV by 0 cycles (registered at the transition).
- `o_busy` is low in the cycle in which `o_frame_done` pulses.

## Configuration
- `SSC_SCAN_TIMEOUT_EN` defined:
  - WAIT counts cycles. At TIMEOUT_CYCLES without `i_adc_done`, set `o_adc_timeout`, which stays set until the next start.
  - That pixel is written as data 0 with flag 0, and the scan continues.
- Not defined:
  - WAIT blocks indefinitely.
  - `o_adc_timeout` is tied to 0.

## Structure
- Package `speckle_scan_pkg` holds:
  - the state enum;
  - the widths `NB_ADDR` and `NB_ACC`;
  - the SR_RST tick count.
- Sub-module `scan_tick_div`: divider with restart input and tick output.

## Test plan
- COLS=4, ROWS=2, k=0, div=0, ADC model returns pixel address×10 → 8 writes at addr 0..7 with data 0,10..70. `o_frame_done` pulses once, then `o_busy` drops.
- k=2, samples 100,102,104,106, umbral=103 → data 0x1067 (flag=1, avg=103). With umbral=104 → 0x0067.
- div=3 → the `row_clk`/`col_clk` high pulse lasts exactly 4 cycles. Exactly one `row_data`=1 per frame and one `col_data`=1 per row, each coincident with a clock high.
- `i_abort` asserted in WAIT of pixel 5 → IDLE next cycle, no further `o_ram_we`, no `o_frame_done`. A new `i_start` then scans from addr 0.
- `i_start` pulsed while busy, and `i_adc_done` pulsed in SETTLE → no effect on write count (8) or data.
- With `SSC_SCAN_TIMEOUT_EN`, TIMEOUT_CYCLES=16, ADC silent for pixel 2 → `o_adc_timeout`=1, addr 2 written as 0x000, the remaining 7 pixels correct.
